// File: rtl/mul_pkg.sv
// Shared constants and state type for the sequential MULT/MULTU multiplier.
// Defining MUL_RADIX4_EN selects the two-bits-per-step datapath (16 iterations).
package mul_pkg;

   localparam int WIDTH = 32;

`ifdef MUL_RADIX4_EN
   localparam int ITER = 16;
`else
   localparam int ITER = 32;
`endif

   localparam int CNT_W = $clog2(ITER);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/mul_seq_if.sv
// Request/result bundle between the pipeline (master) and the multiplier (slave).
interface mul_seq_if;
   import mul_pkg::*;

   logic             start;
   logic             sign;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   modport master (output start, sign, a, b, input hi, lo, busy, done);
   modport slave  (input start, sign, a, b, output hi, lo, busy, done);

endinterface

// File: rtl/mul_step.sv
// One combinational shift-add iteration over the {H,L} accumulator pair.
// With MUL_RADIX4_EN two multiplier bits are retired, using the precomputed 3|a|.
module mul_step
   import mul_pkg::*;
(
   input  logic [WIDTH:0]   i_h,
   input  logic [WIDTH-1:0] i_l,
   input  logic [WIDTH-1:0] i_m1,
`ifdef MUL_RADIX4_EN
   input  logic [WIDTH+1:0] i_m3,
`endif
   output logic [WIDTH:0]   o_h,
   output logic [WIDTH-1:0] o_l
);

`ifdef MUL_RADIX4_EN
   logic [WIDTH+1:0] w_mult;
   logic [WIDTH+1:0] w_sum;

   // H stays below 2^WIDTH between steps, so H + 3|a| always fits in WIDTH+2 bits.
   always_comb begin
      w_mult = '0;
      case (i_l[1:0])
         2'd0: w_mult = '0;
         2'd1: w_mult = {2'b00, i_m1};
         2'd2: w_mult = {1'b0, i_m1, 1'b0};
         2'd3: w_mult = i_m3;
         default: w_mult = '0;
      endcase
      w_sum = {1'b0, i_h} + w_mult;
      o_h   = {1'b0, w_sum[WIDTH+1:2]};
      o_l   = {w_sum[1:0], i_l[WIDTH-1:2]};
   end
`else
   logic [WIDTH:0] w_sum;

   always_comb begin
      w_sum = i_h + (i_l[0] ? {1'b0, i_m1} : '0);
      o_h   = {1'b0, w_sum[WIDTH:1]};
      o_l   = {w_sum[0], i_l[WIDTH-1:1]};
   end
`endif

endmodule

// File: rtl/mul_seq.sv
// Sequential 32x32 multiplier for MULT/MULTU: magnitudes in, conditional negate out.
// Falling-edge clocked; MUL_RADIX4_EN halves the iteration count.
module mul_seq
   import mul_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   mul_seq_if.slave bus
);

   state_t             r_state;
   state_t             w_nextState;
   logic               w_lastStep;
   logic [CNT_W-1:0]   r_count;
   logic [WIDTH:0]     r_h;
   logic [WIDTH-1:0]   r_l;
   logic [WIDTH-1:0]   r_m1;
`ifdef MUL_RADIX4_EN
   logic [WIDTH+1:0]   r_m3;
`endif
   logic               r_neg;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic [WIDTH-1:0]   w_absA;
   logic [WIDTH-1:0]   w_absB;
   logic [WIDTH:0]     w_stepH;
   logic [WIDTH-1:0]   w_stepL;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_result;

   // 0x80000000 negates to itself, which is exactly 2^31 read as unsigned.
   assign w_absA   = (bus.sign && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
   assign w_absB   = (bus.sign && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
   assign w_prod   = {w_stepH[WIDTH-1:0], w_stepL};
   assign w_result = r_neg ? (~w_prod + (2*WIDTH)'(1)) : w_prod;

   mul_step u_step (
      .i_h  (r_h),
      .i_l  (r_l),
      .i_m1 (r_m1),
`ifdef MUL_RADIX4_EN
      .i_m3 (r_m3),
`endif
      .o_h  (w_stepH),
      .o_l  (w_stepL)
   );

   always_ff @(negedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   // A new start always wins and restarts the iteration from scratch.
   always_comb begin
      w_nextState = r_state;
      w_lastStep  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) w_nextState = RUN;
         end
         RUN: begin
            w_lastStep = (r_count == CNT_W'(ITER - 1));
            if (bus.start)       w_nextState = RUN;
            else if (w_lastStep) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // The final step publishes even when a back-to-back start loads on the same edge.
   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_h     <= '0;
         r_l     <= '0;
         r_m1    <= '0;
`ifdef MUL_RADIX4_EN
         r_m3    <= '0;
`endif
         r_neg   <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_lastStep) begin
            {r_hi, r_lo} <= w_result;
            r_done       <= 1'b1;
         end
         if (bus.start) begin
            r_count <= '0;
            r_h     <= '0;
            r_l     <= w_absB;
            r_m1    <= w_absA;
`ifdef MUL_RADIX4_EN
            r_m3    <= {2'b00, w_absA} + {1'b0, w_absA, 1'b0};
`endif
            r_neg   <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         end else if (r_state == RUN) begin
            r_h     <= w_stepH;
            r_l     <= w_stepL;
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;
   assign bus.busy = (r_state == RUN);
   assign bus.done = r_done;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: a scoreboard queue of expected products is
// filled at each start and drained by a monitor whenever done pulses.
module tb_mul_seq;
   import mul_pkg::*;

   logic clock;
   logic reset;

   mul_seq_if busIf ();

   mul_seq dut (
      .clock (clock),
      .reset (reset),
      .bus   (busIf)
   );

   int          errors = 0;
   int          checks = 0;
   logic [63:0] expQ[$];
   logic [63:0] monExp;
   logic [63:0] lastResult;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference product from native 64-bit signed or unsigned multiplication.
   function automatic logic [63:0] refMul(input logic s, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx;
      logic signed [63:0] sy;
      logic [63:0]        ux;
      logic [63:0]        uy;
      if (s) begin
         sx = {{32{x[31]}}, x};
         sy = {{32{y[31]}}, y};
         return 64'(sx * sy);
      end
      ux = {32'd0, x};
      uy = {32'd0, y};
      return ux * uy;
   endfunction

   // Scoreboard drain: every done pulse must match the oldest outstanding request.
   always @(posedge clock) begin
      if (!reset && busIf.done === 1'b1) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_done got=%h_%h required=no done", busIf.hi, busIf.lo);
         end else begin
            monExp = expQ.pop_front();
            if ({busIf.hi, busIf.lo} !== monExp) begin
               errors++;
               $display("[TB] FAIL product got=%h_%h required=%h_%h", busIf.hi, busIf.lo, monExp[63:32], monExp[31:0]);
            end
         end
      end
   end

   // Drives a one-cycle start, then scrambles the operands after the sampling edge.
   task automatic applyStimulus(input logic s, input logic [31:0] av, input logic [31:0] bv, input logic [63:0] expv);
      #1;
      busIf.start = 1'b1;
      busIf.sign  = s;
      busIf.a     = av;
      busIf.b     = bv;
      expQ.push_back(expv);
      @(negedge clock);
      #1;
      busIf.start = 1'b0;
      busIf.sign  = 1'($urandom);
      busIf.a     = $urandom;
      busIf.b     = $urandom;
   endtask

   // Observes posedges until done; index k means k falling edges after the start edge.
   task automatic waitDone(input int k0, input logic [63:0] hold, output int lat, output int busyCnt, output bit stable);
      lat     = -1;
      busyCnt = 0;
      stable  = 1'b1;
      for (int k = k0; k < 200; k++) begin
         @(posedge clock);
         if (busIf.done === 1'b1) begin
            lat = k;
            break;
         end
         if (busIf.busy === 1'b1) busyCnt++;
         if ({busIf.hi, busIf.lo} !== hold) stable = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      busIf.start = 1'b0;
      busIf.sign  = 1'b0;
      busIf.a     = '0;
      busIf.b     = '0;
      repeat (3) @(posedge clock);
      checks++; if (busIf.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b required=0", busIf.busy); end
      checks++; if (busIf.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b required=0", busIf.done); end
      checks++; if (busIf.hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi got=%h required=0", busIf.hi); end
      checks++; if (busIf.lo !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo got=%h required=0", busIf.lo); end
      #1 reset = 1'b0;
      lastResult = '0;
   endtask

   task automatic test_unsigned();
      int lat, bc;
      bit st;
      @(posedge clock);
      applyStimulus(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
      waitDone(0, lastResult, lat, bc, st);
      checks++; if (lat !== ITER) begin errors++; $display("[TB] FAIL unsigned_latency got=%0d required=%0d", lat, ITER); end
      checks++; if (bc !== ITER) begin errors++; $display("[TB] FAIL unsigned_busy_cycles got=%0d required=%0d", bc, ITER); end
      checks++; if (busIf.busy !== 1'b0) begin errors++; $display("[TB] FAIL unsigned_busy_at_done got=%b required=0", busIf.busy); end
      checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL unsigned_hold got=changed required=stable"); end
      @(posedge clock);
      checks++; if (busIf.done !== 1'b0) begin errors++; $display("[TB] FAIL unsigned_done_pulse got=%b required=0", busIf.done); end
      lastResult = 64'hFFFFFFFE_00000001;
   endtask

   task automatic test_signed();
      logic        tS[5];
      logic [31:0] tA[5];
      logic [31:0] tB[5];
      logic [63:0] tE[5];
      int lat, bc;
      bit st;
      tS = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      tA = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'h00000000};
      tB = '{32'h00000007, 32'h00000007, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
      tE = '{64'hFFFFFFFF_FFFFFFEB, 64'h00000006_FFFFFFEB, 64'h40000000_00000000,
             64'hFFFFFFFF_80000000, 64'h00000000_00000000};
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         applyStimulus(tS[i], tA[i], tB[i], tE[i]);
         waitDone(0, lastResult, lat, bc, st);
         checks++; if (lat !== ITER) begin errors++; $display("[TB] FAIL signed_latency[%0d] got=%0d required=%0d", i, lat, ITER); end
         checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL signed_hold[%0d] got=changed required=stable", i); end
         lastResult = tE[i];
      end
   endtask

   task automatic test_random();
      logic        s;
      logic [31:0] x, y;
      logic [63:0] e;
      int lat, bc;
      bit st;
      for (int i = 0; i < 6; i++) begin
         s = 1'($urandom);
         x = $urandom;
         y = (i == 5) ? 32'hFFFFFFFF : $urandom;
         e = refMul(s, x, y);
         @(posedge clock);
         applyStimulus(s, x, y, e);
         waitDone(0, lastResult, lat, bc, st);
         checks++; if (lat !== ITER) begin errors++; $display("[TB] FAIL random_latency[%0d] got=%0d required=%0d", i, lat, ITER); end
         lastResult = e;
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] e1, e2;
      int lat, bc;
      bit st;
      e1 = refMul(1'b0, 32'h12345678, 32'h9ABCDEF0);
      e2 = refMul(1'b1, 32'hFFFFFF00, 32'h00012345);
      @(posedge clock);
      applyStimulus(1'b0, 32'h12345678, 32'h9ABCDEF0, e1);
      repeat (ITER) @(posedge clock);
      applyStimulus(1'b1, 32'hFFFFFF00, 32'h00012345, e2);
      @(posedge clock);
      checks++; if (busIf.done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_done got=%b required=1", busIf.done); end
      checks++; if (busIf.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy got=%b required=1", busIf.busy); end
      waitDone(1, e1, lat, bc, st);
      checks++; if (lat !== ITER) begin errors++; $display("[TB] FAIL b2b_latency got=%0d required=%0d", lat, ITER); end
      checks++; if (bc !== ITER - 1) begin errors++; $display("[TB] FAIL b2b_busy_cycles got=%0d required=%0d", bc, ITER - 1); end
      checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL b2b_hold got=changed required=stable"); end
      lastResult = e2;
      @(posedge clock);
      checks++; if (busIf.done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_pulse got=%b required=0", busIf.done); end
   endtask

   task automatic test_abort();
      logic [63:0] hold;
      int lat, bc;
      bit st, quiet;
      hold  = lastResult;
      quiet = 1'b1;
      @(posedge clock);
      applyStimulus(1'b0, 32'd5, 32'd6, 64'd30);
      for (int k = 0; k < 4; k++) begin
         @(posedge clock);
         if (busIf.done !== 1'b0 || {busIf.hi, busIf.lo} !== hold) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) begin errors++; $display("[TB] FAIL abort_quiet_before got=activity required=none"); end
      void'(expQ.pop_back());
      applyStimulus(1'b0, 32'd9, 32'd9, 64'd81);
      waitDone(0, hold, lat, bc, st);
      checks++; if (lat !== ITER) begin errors++; $display("[TB] FAIL abort_latency got=%0d required=%0d", lat, ITER); end
      checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL abort_hold got=changed required=stable"); end
      checks++; if (busIf.lo !== 32'd81) begin errors++; $display("[TB] FAIL abort_lo got=%0d required=81", busIf.lo); end
      lastResult = 64'd81;
   endtask

   task automatic test_reset_mid();
      logic [63:0] e;
      int lat, bc;
      bit st;
      @(posedge clock);
      applyStimulus(1'b1, 32'h87654321, 32'h0FEDCBA9, refMul(1'b1, 32'h87654321, 32'h0FEDCBA9));
      repeat (10) @(posedge clock);
      #1 reset = 1'b1;
      #1;
      checks++; if (busIf.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got=%b required=0", busIf.busy); end
      checks++; if (busIf.done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done got=%b required=0", busIf.done); end
      checks++; if ({busIf.hi, busIf.lo} !== 64'd0) begin errors++; $display("[TB] FAIL midreset_hilo got=%h_%h required=0", busIf.hi, busIf.lo); end
      expQ.delete();
      lastResult = '0;
      @(posedge clock);
      #1 reset = 1'b0;
      e = 64'hFFFFFFFF_FFFFFFD6;
      @(posedge clock);
      applyStimulus(1'b1, 32'hFFFFFFF9, 32'd6, e);
      waitDone(0, lastResult, lat, bc, st);
      checks++; if (lat !== ITER) begin errors++; $display("[TB] FAIL postreset_latency got=%0d required=%0d", lat, ITER); end
      checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL postreset_hold got=changed required=stable"); end
      lastResult = e;
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_random();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      repeat (3) @(posedge clock);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL pending_results got=%0d required=0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("[TB] FAIL watchdog got=timeout required=completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
